fault_event_logger: RTL and testbench

//  Downstream consumer of the fault-protection stage. Samples its fault code (out[2:0]),

---
 rtl/fault_event_logger.sv | 215 +++++++++++++++++++++
 tb/tb_fault_event_logger.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fault_event_logger.sv
// ---------------------------------------------------------------------------
// fault_event_logger
//
// Watches the fault-protection stage and records fault events for the host.
// A new event is a non-zero fault code whose {code, severity} pair differs
// from the previous cycle's sample. Events go into a small show-ahead FIFO
// together with the co-processor result bit. A saturating event counter
// and two sticky flags (overflow, critical) summarise the activity.
//
// Ports
//   clk         in   1      system clock, all logic on the rising edge
//   reset       in   1      synchronous active-high reset, overrides everything
//   fault_code  in   3      fault class, 3'b000 = no fault
//   fault_sev   in   2      fault severity, 2'b11 = critical
//   cop_q       in   1      co-processor result bit, stored with each event
//   rd_en       in   1      pop the head entry (ignored while empty)
//   clr         in   1      clear FIFO, counter and sticky flags
//   rd_data     out  6      head entry {sev, code, cop_q}, 0 when empty
//   evt_valid   out  1      FIFO not empty
//   evt_count   out  CNT_W  events since reset/clr, saturating at all-ones
//   overflow    out  1      sticky: an event was dropped on a full FIFO
//   crit        out  1      sticky: a critical event was accepted
//
// All outputs come straight from flops. The head entry is precomputed from
// next-state values so that it is valid in the cycle after a push into an
// empty FIFO, with no combinational path from the inputs.
// ---------------------------------------------------------------------------
module fault_event_logger #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       fault_code,
  input  logic [1:0]       fault_sev,
  input  logic             cop_q,
  input  logic             rd_en,
  input  logic             clr,
  output logic [5:0]       rd_data,
  output logic             evt_valid,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  output logic             crit
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW:0]      OCC_ZERO = {(AW + 1){1'b0}};
  localparam logic [AW:0]      OCC_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]      OCC_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]    PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]    PTR_ONE  = {{(AW - 1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W - 1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Storage and state registers
  logic [5:0]       mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             crit_q, crit_d;
  logic [2:0]       prev_code_q;
  logic [1:0]       prev_sev_q;
  logic [5:0]       head_q, head_d;
  logic             valid_q, valid_d;

  // Per-cycle decode
  logic       is_event_s;
  logic       empty_s;
  logic       full_s;
  logic       pop_s;
  logic       push_s;
  logic       drop_s;
  logic [5:0] entry_s;

  // Event detection and push/pop/drop decisions for this cycle
  always_comb begin
    is_event_s = 1'b0;
    empty_s    = 1'b0;
    full_s     = 1'b0;
    pop_s      = 1'b0;
    push_s     = 1'b0;
    drop_s     = 1'b0;
    entry_s    = {fault_sev, fault_code, cop_q};

    // A held fault logs once; a severity change on the same code is new.
    is_event_s = (fault_code != 3'b000) &&
                 ({fault_code, fault_sev} != {prev_code_q, prev_sev_q});
    empty_s    = (occ_q == OCC_ZERO);
    full_s     = (occ_q == OCC_FULL);

    if (clr) begin
      // clr discards any same-cycle event and any pop.
      pop_s  = 1'b0;
      push_s = 1'b0;
      drop_s = 1'b0;
    end else begin
      pop_s  = rd_en && !empty_s;
      // A pop in the same cycle frees the slot the push needs.
      push_s = is_event_s && (!full_s || pop_s);
      drop_s = is_event_s && full_s && !pop_s;
    end
  end

  // Next-state for pointers, occupancy, counter, flags and the output head
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    crit_d   = crit_q;
    head_d   = 6'b000000;
    valid_d  = 1'b0;

    if (clr) begin
      rd_ptr_d = PTR_ZERO;
      wr_ptr_d = PTR_ZERO;
      occ_d    = OCC_ZERO;
      cnt_d    = CNT_ZERO;
      ovf_d    = 1'b0;
      crit_d   = 1'b0;
    end else begin
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end

      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase

      // Dropped events still count.
      if (is_event_s && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end

      ovf_d  = ovf_q | drop_s;
      crit_d = crit_q | (push_s && (fault_sev == 2'b11));
    end

    // Head seen next cycle: a push into an empty FIFO lands at the new
    // read pointer, so bypass the entry instead of reading stale storage.
    if (occ_d == OCC_ZERO) begin
      head_d  = 6'b000000;
      valid_d = 1'b0;
    end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
      head_d  = entry_s;
      valid_d = 1'b1;
    end else begin
      head_d  = mem_q[rd_ptr_d];
      valid_d = 1'b1;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 6'b000000;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  // Control and status state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= PTR_ZERO;
      wr_ptr_q    <= PTR_ZERO;
      occ_q       <= OCC_ZERO;
      cnt_q       <= CNT_ZERO;
      ovf_q       <= 1'b0;
      crit_q      <= 1'b0;
      prev_code_q <= 3'b000;
      prev_sev_q  <= 2'b00;
      head_q      <= 6'b000000;
      valid_q     <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      crit_q      <= crit_d;
      // History is tracked even while clr is asserted.
      prev_code_q <= fault_code;
      prev_sev_q  <= fault_sev;
      head_q      <= head_d;
      valid_q     <= valid_d;
    end
  end

  assign rd_data   = head_q;
  assign evt_valid = valid_q;
  assign evt_count = cnt_q;
  assign overflow  = ovf_q;
  assign crit      = crit_q;

endmodule

// File: tb/tb_fault_event_logger.sv
module tb_fault_event_logger;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [2:0]       fault_code;
  logic [1:0]       fault_sev;
  logic             cop_q;
  logic             rd_en;
  logic             clr;
  logic [5:0]       rd_data;
  logic             evt_valid;
  logic [CNT_W-1:0] evt_count;
  logic             overflow;
  logic             crit;

  int vectors;
  int miscompares;

  // Reference model: queue of logged entries plus counters/flags
  logic [5:0] mq[$];
  int         m_cnt;
  bit         m_ovf;
  bit         m_crit;
  logic [2:0] m_pc;
  logic [1:0] m_ps;

  fault_event_logger #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .fault_code(fault_code), .fault_sev(fault_sev),
    .cop_q(cop_q), .rd_en(rd_en), .clr(clr), .rd_data(rd_data),
    .evt_valid(evt_valid), .evt_count(evt_count), .overflow(overflow), .crit(crit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] exp_head();
    if (mq.size() > 0) return mq[0];
    return 6'b000000;
  endfunction

  // Apply one cycle of inputs, advance the model, settle 1 time unit past the edge
  task automatic tick(input logic r, input logic [2:0] c, input logic [1:0] s,
                      input logic q, input logic rd, input logic cl);
    bit ev;
    reset = r; fault_code = c; fault_sev = s; cop_q = q; rd_en = rd; clr = cl;
    @(posedge clk);
    if (r) begin
      mq.delete(); m_cnt = 0; m_ovf = 0; m_crit = 0; m_pc = 3'b000; m_ps = 2'b00;
    end else begin
      ev = (c != 3'b000) && ({c, s} != {m_pc, m_ps});
      if (cl) begin
        mq.delete(); m_cnt = 0; m_ovf = 0; m_crit = 0;
      end else begin
        if (rd && mq.size() > 0) void'(mq.pop_front());
        if (ev) begin
          if (mq.size() < DEPTH) begin
            mq.push_back({s, c, q});
            if (s == 2'b11) m_crit = 1;
          end else begin
            m_ovf = 1;
          end
          if (m_cnt < CNT_MAX) m_cnt++;
        end
      end
      m_pc = c; m_ps = s;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if ({rd_data, evt_valid, evt_count, overflow, crit} !== {6'd0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state got rd=%b v=%b cnt=%0d ovf=%b crit=%b exp all 0",
               rd_data, evt_valid, evt_count, overflow, crit);
    end
  endtask

  task automatic test_hold();
    tick(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 3'b101, 2'b01, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (rd_data !== 6'b011011 || evt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_first got rd=%b v=%b exp rd=011011 v=1", rd_data, evt_valid);
    end
    for (int i = 0; i < 4; i++) tick(1'b0, 3'b101, 2'b01, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (evt_count !== 4'd1 || mq.size() != 1 || rd_data !== exp_head()) begin
      miscompares++;
      $display("FAIL hold_once got cnt=%0d rd=%b exp cnt=1 rd=%b", evt_count, rd_data, exp_head());
    end
    tick(1'b0, 3'b101, 2'b01, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (evt_valid !== 1'b0 || rd_data !== 6'd0) begin
      miscompares++;
      $display("FAIL hold_pop got v=%b rd=%b exp v=0 rd=0", evt_valid, rd_data);
    end
  endtask

  task automatic test_overflow();
    logic [5:0] exp_e;
    tick(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++)
      tick(1'b0, (i % 2 == 0) ? 3'd1 : 3'd2, 2'd0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    vectors++;
    if (evt_count !== 4'd6 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_flags got cnt=%0d ovf=%b exp cnt=6 ovf=1", evt_count, overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp_e = exp_head();
      vectors++;
      if (rd_data !== exp_e || rd_data[3:1] !== ((i % 2 == 0) ? 3'd1 : 3'd2)) begin
        miscompares++;
        $display("FAIL ovf_order idx=%0d got=%b exp=%b", i, rd_data, exp_e);
      end
      tick(1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    end
    vectors++;
    if (evt_valid !== 1'b0 || rd_data !== 6'd0) begin
      miscompares++;
      $display("FAIL ovf_drained got v=%b rd=%b exp v=0 rd=0", evt_valid, rd_data);
    end
  endtask

  task automatic test_full_pop();
    tick(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      tick(1'b0, (i % 2 == 0) ? 3'd1 : 3'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 3'd3, 2'd1, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (overflow !== 1'b0 || evt_valid !== 1'b1 || mq.size() != DEPTH) begin
      miscompares++;
      $display("FAIL fullpop_flags got ovf=%b v=%b exp ovf=0 v=1", overflow, evt_valid);
    end
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (rd_data !== exp_head()) begin
        miscompares++;
        $display("FAIL fullpop_order idx=%0d got=%b exp=%b", i, rd_data, exp_head());
      end
      if (i == DEPTH - 1) begin
        vectors++;
        if (rd_data !== 6'b010111) begin
          miscompares++;
          $display("FAIL fullpop_last got=%b exp=010111", rd_data);
        end
      end
      tick(1'b0, 3'd3, 2'd1, 1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic test_saturate();
    tick(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, (i % 2 == 0) ? 3'd1 : 3'd2, 2'd2, 1'b0, (i % 2 == 1), 1'b0);
      vectors++;
      if (evt_count !== m_cnt[CNT_W-1:0] || evt_count === 4'd0) begin
        miscompares++;
        $display("FAIL sat_step i=%0d got=%0d exp=%0d", i, evt_count, m_cnt);
      end
    end
    vectors++;
    if (evt_count !== 4'hF) begin
      miscompares++;
      $display("FAIL sat_final got=%0d exp=15", evt_count);
    end
  endtask

  task automatic test_crit_clr();
    tick(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 3'd4, 2'b11, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (crit !== 1'b1 || rd_data !== 6'b111000) begin
      miscompares++;
      $display("FAIL crit_set got crit=%b rd=%b exp crit=1 rd=111000", crit, rd_data);
    end
    tick(1'b0, 3'd6, 2'b10, 1'b1, 1'b0, 1'b1);
    vectors++;
    if ({evt_valid, evt_count, overflow, crit} !== 7'd0) begin
      miscompares++;
      $display("FAIL clr_event got v=%b cnt=%0d ovf=%b crit=%b exp all 0",
               evt_valid, evt_count, overflow, crit);
    end
    tick(1'b0, 3'd6, 2'b10, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (evt_valid !== 1'b0 || evt_count !== 4'd0) begin
      miscompares++;
      $display("FAIL clr_hold got v=%b cnt=%0d exp v=0 cnt=0", evt_valid, evt_count);
    end
  endtask

  task automatic test_random();
    logic [2:0] c;
    logic [1:0] s;
    c = 3'd0; s = 2'd0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        c = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
        s = 2'($urandom_range(0, 3));
      end
      tick(($urandom_range(0, 99) == 0), c, s, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 39) == 0));
      vectors++;
      if (rd_data !== exp_head() || evt_valid !== (mq.size() > 0) ||
          evt_count !== m_cnt[CNT_W-1:0] || overflow !== m_ovf || crit !== m_crit) begin
        miscompares++;
        $display("FAIL rand cyc=%0d got rd=%b v=%b cnt=%0d ovf=%b crit=%b exp rd=%b v=%b cnt=%0d ovf=%b crit=%b",
                 i, rd_data, evt_valid, evt_count, overflow, crit,
                 exp_head(), (mq.size() > 0), m_cnt, m_ovf, m_crit);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_cnt = 0; m_ovf = 0; m_crit = 0; m_pc = 3'b000; m_ps = 2'b00;
    reset = 1'b1; fault_code = 3'd0; fault_sev = 2'd0; cop_q = 1'b0; rd_en = 1'b0; clr = 1'b0;
    test_reset();
    test_hold();
    test_overflow();
    test_full_pop();
    test_saturate();
    test_crit_clr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
